// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes qa/qb, decodes Gray-code steps into a
// WIDTH-bit position with clear/load/count-enable. Optional filter: QUAD_DECODER_GLITCH_FILTER_EN.
module quad_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             qa,
  input  logic             qb,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] datain,
  input  logic             counten,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             wrap
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef QUAD_DECODER_GLITCH_FILTER_EN
  localparam int FILT_CYC = (FILT_LEN < 1) ? 1 : FILT_LEN;
`else
  localparam int FILT_CYC = 0 * FILT_LEN;
`endif
  // Priming spans the whole pin-to-ab pipeline so reset values never get decoded.
  localparam int PRIME_CYC = SYNC_N + FILT_CYC + 1;
  localparam int PW        = $clog2(PRIME_CYC + 1);

  // Maps a Gray phase pair onto its position in the forward cycle 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  logic [1:0]       sync_q [SYNC_N];
  logic [1:0]       ab_s;
  logic [1:0]       prev_ab_q, prev_ab_d;
  logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
  logic [1:0]       delta_s;
  logic             primed_s;
  logic             up_s, dn_s, bad_s;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;

  // Pin synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_N; i++) sync_q[i] <= 2'b00;
    end else begin
      sync_q[0] <= {qa, qb};
      for (int i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef QUAD_DECODER_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_CYC + 1);

  logic [1:0]    cand_q;
  logic [1:0]    ab_filt_q;
  logic [CW-1:0] fcnt_q;

  // Accepts a candidate pair only after it has been stable for FILT_CYC samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= 2'b00;
      ab_filt_q <= 2'b00;
      fcnt_q    <= CW'(FILT_CYC);
    end else if (sync_q[SYNC_N-1] != cand_q) begin
      cand_q <= sync_q[SYNC_N-1];
      fcnt_q <= CW'(1);
      if (FILT_CYC == 1) ab_filt_q <= sync_q[SYNC_N-1];
    end else if (fcnt_q < CW'(FILT_CYC)) begin
      fcnt_q <= fcnt_q + CW'(1);
      if (fcnt_q == CW'(FILT_CYC - 1)) ab_filt_q <= cand_q;
    end
  end

  assign ab_s = ab_filt_q;
`else
  assign ab_s = sync_q[SYNC_N-1];
`endif

  assign primed_s = (prime_cnt_q == PW'(PRIME_CYC));
  assign delta_s  = gray_pos(ab_s) - gray_pos(prev_ab_q);

  // Classifies the phase movement since the previous sample.
  always_comb begin
    up_s  = 1'b0;
    dn_s  = 1'b0;
    bad_s = 1'b0;
    if (primed_s) begin
      case (delta_s)
        2'd1:    up_s  = 1'b1;
        2'd3:    dn_s  = 1'b1;
        2'd2:    bad_s = 1'b1;
        default: bad_s = 1'b0;
      endcase
    end else begin
      bad_s = 1'b0;
    end
  end

  // Position update: clear beats load beats a counted step.
  always_comb begin
    prev_ab_d   = ab_s;
    prime_cnt_d = prime_cnt_q;
    out_d       = out_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    err_d       = bad_s;
    wrap_d      = 1'b0;
    if (!primed_s) begin
      prime_cnt_d = prime_cnt_q + PW'(1);
    end else begin
      prime_cnt_d = prime_cnt_q;
    end
    if (clear) begin
      out_d = {WIDTH{1'b0}};
    end else if (load) begin
      out_d = datain;
    end else if (counten && up_s) begin
      out_d  = out_q + WIDTH'(1);
      dir_d  = 1'b1;
      step_d = 1'b1;
      wrap_d = (out_q == {WIDTH{1'b1}});
    end else if (counten && dn_s) begin
      out_d  = out_q - WIDTH'(1);
      dir_d  = 1'b0;
      step_d = 1'b1;
      wrap_d = (out_q == {WIDTH{1'b0}});
    end else begin
      out_d = out_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab_q   <= 2'b00;
      prime_cnt_q <= {PW{1'b0}};
      out_q       <= {WIDTH{1'b0}};
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      prev_ab_q   <= prev_ab_d;
      prime_cnt_q <= prime_cnt_d;
      out_q       <= out_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out  = out_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: stimulus queues expected step/err/wrap events,
// a negedge monitor pops and compares them; directed checks cover position values.
module tb_quad_decoder;

  localparam int SYNC = 2;
`ifdef QUAD_DECODER_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 3 + 1;
`else
  localparam int LAT = SYNC + 1;
`endif

  typedef struct packed {
    logic       step;
    logic       err;
    logic       wrap;
    logic       dir;
    logic [7:0] out;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n, qa, qb, clear, load, counten;
  logic [7:0] datain;
  logic [7:0] out;
  logic       dir, step, err, wrap;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  quad_decoder #(.WIDTH(8), .SYNC_STAGES(SYNC), .FILT_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .qa(qa), .qb(qb), .clear(clear), .load(load),
    .datain(datain), .counten(counten), .out(out), .dir(dir), .step(step),
    .err(err), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (step || err || wrap)) begin
      ev_t got, e;
      got = '{step: step, err: err, wrap: wrap, dir: dir, out: out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got step=%0b err=%0b wrap=%0b dir=%0b out=%02h, required none",
                 step, err, wrap, dir, out);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL event got step=%0b err=%0b wrap=%0b dir=%0b out=%02h, required step=%0b err=%0b wrap=%0b dir=%0b out=%02h",
                   step, err, wrap, dir, out, e.step, e.err, e.wrap, e.dir, e.out);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic push(input logic s, input logic e, input logic w, input logic d, input logic [7:0] o);
    exp_q.push_back('{step: s, err: e, wrap: w, dir: d, out: o});
  endtask

  task automatic phase(input logic [1:0] p);
    @(negedge clk);
    {qa, qb} = p;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic load_val(input logic [7:0] v, input logic with_clear);
    @(negedge clk);
    load = 1'b1; clear = with_clear; datain = v;
    @(negedge clk);
    load = 1'b0; clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; qa = 1'b1; qb = 1'b1; clear = 1'b0; load = 1'b0;
    datain = 8'h00; counten = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out", out, 32'h0);
    check("rst_dir", dir, 32'h0);
    check("rst_step", step, 32'h0);
    check("rst_err", err, 32'h0);
    check("rst_wrap", wrap, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("prime_out", out, 32'h0);

    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
    phase(2'b10);
    check("first_step_out", out, 32'h01);

    // Asynchronous reset between clock edges, then re-prime from 00.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 32'h0);
    check("async_rst_dir", dir, 32'h0);
    {qa, qb} = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    begin
      logic [1:0] fwd [4];
      fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[2] = 2'b10; fwd[3] = 2'b00;
      for (int i = 0; i < 8; i++) begin
        push(1'b1, 1'b0, 1'b0, 1'b1, 8'(i + 1));
        phase(fwd[i % 4]);
      end
    end
    check("fwd8_out", out, 32'h08);
    check("fwd8_dir", dir, 32'h1);

    push(1'b1, 1'b0, 1'b0, 1'b0, 8'h07); phase(2'b10);
    push(1'b1, 1'b0, 1'b0, 1'b0, 8'h06); phase(2'b11);
    push(1'b1, 1'b0, 1'b0, 1'b0, 8'h05); phase(2'b01);
    check("rev3_out", out, 32'h05);
    check("rev3_dir", dir, 32'h0);

    load_val(8'hFF, 1'b0);
    check("load_ff", out, 32'hFF);
    push(1'b1, 1'b0, 1'b1, 1'b1, 8'h00); phase(2'b11);
    check("wrap_up_out", out, 32'h00);
    push(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF); phase(2'b01);
    check("wrap_dn_out", out, 32'hFF);

    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF); phase(2'b10);
    check("err_hold_out", out, 32'hFF);

    load_val(8'h00, 1'b1);
    check("clear_out", out, 32'h00);
    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h01); phase(2'b00);
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'h01); phase(2'b11);
    check("err_00_11_out", out, 32'h01);

    // Forward step 11->10 lands on the same edge as clear: step is dropped.
    @(negedge clk);
    {qa, qb} = 2'b10;
    repeat (LAT - 1) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check("step_vs_clear_out", out, 32'h00);

    load_val(8'h33, 1'b0);
    check("load_33", out, 32'h33);
    load_val(8'h5A, 1'b1);
    check("load_and_clear", out, 32'h00);

    counten = 1'b0;
    phase(2'b00); phase(2'b01); phase(2'b11); phase(2'b10);
    check("counten0_out", out, 32'h00);
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'h00); phase(2'b01);
    counten = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h01); phase(2'b11);
    check("reenable_out", out, 32'h01);

    // Pin-to-output latency of a single forward step 11->10.
    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h02);
    @(negedge clk);
    {qa, qb} = 2'b10;
    repeat (LAT - 1) @(posedge clk);
    #1 check("latency_early_step", step, 32'h0);
    @(posedge clk);
    #1 check("latency_step", step, 32'h1);
    check("latency_out", out, 32'h02);
    repeat (4) @(negedge clk);

`ifdef QUAD_DECODER_GLITCH_FILTER_EN
    @(negedge clk);
    qa = 1'b0;
    repeat (2) @(negedge clk);
    qa = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check("glitch_out", out, 32'h02);
    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h03); phase(2'b00);
    check("filtered_step_out", out, 32'h03);
`endif

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature position decoder for incremental rotary/linear encoders. Samples the two phase inputs `qa`/`qb` from the pin side, decodes legal Gray-code transitions into up/down steps, and keeps a WIDTH-bit position counter with the same clear/load/count-enable controls as the team's up/down counter. Sits between the encoder pads and any consumer of position (PWM loop, register bank); `out` is a drop-in source wherever a counter value is read.

## Interface
- `WIDTH`: default 8. Position counter width.
- `SYNC_STAGES`: default 2. Synchronizer flops on `qa`/`qb`; minimum 2.
- `FILT_LEN`: default 3. Stability window in cycles. Used only with the filter macro.
- `clk`: input, 1. Single clock; all state on rising edge.
- `rst_n`: input, 1. Asynchronous, active-low reset.
- `qa`, `qb`: input, 1 each. Asynchronous encoder phases.
- `clear`: input, 1. Synchronous; position := 0.
- `load`: input, 1. Synchronous; position := `datain`.
- `datain`: input, WIDTH. Load value.
- `counten`: input, 1. When 0, decoded steps are discarded; phase tracking continues.
- `out`: output, WIDTH. Current position.
- `dir`: output, 1. Direction of last counted step; 1 = up.
- `step`: output, 1. One-cycle pulse per counted step.
- `err`: output, 1. One-cycle pulse on an illegal (double) phase change.
- `wrap`: output, 1. One-cycle pulse when a counted step wraps `out`.

## Operation
- Pipeline: `qa`/`qb` → SYNC_STAGES flops → sampled pair `ab` = {qa,qb} → compared with `prev_ab`; `prev_ab` := `ab` every cycle.
- Forward sequence 00→01→11→10→00 is +1. Reverse is −1. `ab == prev_ab` produces no action.
- Illegal transitions 00↔11 and 01↔10: `err` pulses; no count; `prev_ab` still updates.
- Priming: the first sampled pair after reset release only loads `prev_ab`. It never counts and never flags `err`, regardless of pin levels.
- Priority each cycle: `clear` > `load` > counted step. A step coinciding with `clear` or `load` is dropped, with no `step`/`wrap`/`dir` update. `err` is independent of this priority.
- Counted step (legal, `counten`=1, no clear/load):
  - `out` ± 1, modulo 2^WIDTH.
  - `step`=1 and `dir` := direction, both on the same edge as `out`.
- Wrap: (2^WIDTH−1)+1 → 0 and 0−1 → (2^WIDTH−1) set `wrap`=1 with the update. `wrap` never asserts on load/clear.
- `counten`=0: legal steps are lost, not queued. `out`, `dir` and `step` hold; `err` still reported.
- Reset values: `out`=0, `dir`=0, `step`=0, `err`=0, `wrap`=0. Sync flops and `prev_ab` = 00; primed flag cleared.
- Reset asserted mid-operation: all of the above takes effect immediately (asynchronous), and priming repeats after release.

## Timing
- Pin edge to `out`/`step`/`err` update: SYNC_STAGES+1 rising edges without the filter; SYNC_STAGES+FILT_LEN+1 with it.
- `clear`/`load`: `out` updates on the first rising edge where the input is sampled high. Latency 1.
- Maximum step rate: one transition per decode cycle. The encoder must hold each phase state at least 2 cycles (FILT_LEN+1 with the filter); faster input is unspecified except that two-bit changes report `err`.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `QUAD_DECODER_GLITCH_FILTER_EN` defined:
  - After the synchronizer, a candidate pair is accepted into `ab` only after it is identical for FILT_LEN consecutive cycles.
  - Shorter pulses are ignored entirely: no step, no `err`.
  - The counter restarts on any change of the candidate pair.
- Undefined: no filter hardware; the synchronizer output feeds `ab` directly. `FILT_LEN` is ignored.

## Test plan
- Reset with `qa`=`qb`=1, release, hold 10 cycles → `out`=0, no `step`/`err` pulses (priming).
- From `out`=0, `counten`=1, drive 8 forward transitions (00,01,11,10,00,…) → `out`=8, `dir`=1, 8 `step` pulses; then 3 reverse transitions → `out`=5, `dir`=0.
- Load `datain`=0xFF, then 1 forward step → `out`=0x00, `wrap` pulse 1 cycle. Then 1 reverse step → `out`=0xFF, second `wrap` pulse.
- Phases 00→11 in one cycle → single `err` pulse, `out` unchanged. Step coincident with `clear` → `out`=0, no `step`. `load`+`clear` together → `out`=0.
- `counten`=0 across 4 forward steps → `out` unchanged, no `step`. Re-enable then 1 step → `out`+1.
- Filter macro defined, FILT_LEN=3: 2-cycle glitch on `qa` → no `step`/`err`. 3-cycle-stable transition → one step at SYNC_STAGES+4 edges after the pin change.
